bt_channel: RTL and testbench

// - Selector-style IBM bus-and-tag I/O channel; single-device ops over one bus/tag (A) interface.
// - Host side: start/stop, unit address, CCW command byte, 2-bit condition code, AXI-Stream-style byte data.
// - Runs initial selection, data transfer and ending status with one control unit (CU) on the chain.

---
 rtl/bt_channel_pkg.sv | 49 ++++
 rtl/bt_channel_parity.sv | 9 +
 rtl/bt_channel.sv | 336 +++++++++++++++++++++++++++++++++
 tb/tb_bt_channel.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bt_channel_pkg.sv
// bt_channel_pkg: shared types and constants for the bus-and-tag selector channel.
//   - bt_state_e    : channel sequencing FSM states
//   - CMD_*         : CCW command codes understood by the host/CU pair
//   - ST_*          : status byte bit positions and masks
//   - CC_*          : condition codes reported to the host
//   - SEL_TIMEOUT   : cycles to wait for a CU to answer selection
package bt_channel_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SELECT      = 3'd1,
        COMMAND     = 3'd2,
        INIT_STATUS = 3'd3,
        DATA        = 3'd4,
        END         = 3'd5
    } bt_state_e;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] CMD_NOP   = 8'h03;

    localparam int ST_BUSY_BIT = 4;
    localparam int ST_CE_BIT   = 3;
    localparam int ST_DE_BIT   = 2;
    localparam int ST_UC_BIT   = 1;

    localparam logic [7:0] ST_BUSY = 8'h10;
    localparam logic [7:0] ST_CE   = 8'h08;
    localparam logic [7:0] ST_DE   = 8'h04;
    localparam logic [7:0] ST_UC   = 8'h02;

    localparam logic [1:0] CC_STARTED  = 2'd0;
    localparam logic [1:0] CC_STORED   = 2'd1;
    localparam logic [1:0] CC_BUSY     = 2'd2;
    localparam logic [1:0] CC_NOT_OPER = 2'd3;

    // A CU that neither answers nor returns select within this many cycles
    // of SELECT entry is treated as absent.
    localparam logic [4:0] SEL_TIMEOUT = 5'd16;

    function automatic logic cmd_is_read(input logic [7:0] c);
        return (c[1:0] == 2'b10);
    endfunction

    function automatic logic cmd_is_write(input logic [7:0] c);
        return c[0];
    endfunction

endpackage

// File: rtl/bt_channel_parity.sv
// odd_parity: combinational odd-parity generator for one bus byte.
//   data   in  8  byte on the bus
//   parity out 1  bit that makes the 9-bit word have an odd number of ones
module odd_parity (
    input  logic [7:0] data,
    output logic       parity
);
    assign parity = ~^data;
endmodule

// File: rtl/bt_channel.sv
// bt_channel: selector-style bus-and-tag channel driving one chain (A) with a
// single control unit. Runs initial selection, command transfer, initial
// status, byte-at-a-time data transfer and ending status for one CCW.
//
// Ports
//   clk, reset            clock / asynchronous active-low reset
//   enable                raises a_operational_out; low forces IDLE, no tags
//   a_bus_out[_parity]    channel->CU byte with odd parity
//   a_bus_in[_parity]     CU->channel byte with odd parity
//   a_*_out               outbound tags (operational, hold, select, address,
//                         command, service, suppress)
//   a_*_in                inbound tags (operational, request, select, address,
//                         status, service)
//   addr, command, start  unit address and CCW command, taken on start
//   stop                  host stop request, remembered until the op ends
//   condition_code        0 started, 1 status stored, 2 busy, 3 not operational
//   status                last status byte accepted from the CU
//   data_send_*           AXI-Stream style write data from the host
//   data_recv_*           AXI-Stream style read data to the host
//
// Build option: define BT_CHANNEL_PARITY_CHECK_EN to check a_bus_in parity on
// every sampled byte; a mismatch reports unit check with condition code 1.
module bt_channel
    import bt_channel_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic [7:0] a_bus_out,
    output logic       a_bus_out_parity,
    input  logic [7:0] a_bus_in,
    input  logic       a_bus_in_parity,
    output logic       a_operational_out,
    output logic       a_hold_out,
    output logic       a_select_out,
    output logic       a_address_out,
    output logic       a_command_out,
    output logic       a_service_out,
    output logic       a_suppress_out,
    input  logic       a_operational_in,
    input  logic       a_request_in,
    input  logic       a_select_in,
    input  logic       a_address_in,
    input  logic       a_status_in,
    input  logic       a_service_in,
    input  logic [7:0] addr,
    input  logic [7:0] command,
    input  logic       start,
    input  logic       stop,
    output logic [1:0] condition_code,
    output logic [7:0] status,
    input  logic [7:0] data_send_tdata,
    input  logic       data_send_tvalid,
    output logic       data_send_tready,
    output logic [7:0] data_recv_tdata,
    output logic       data_recv_tvalid,
    input  logic       data_recv_tready
);

    bt_state_e  state_q, state_d;
    logic [7:0] bus_q, bus_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] status_q, status_d;
    logic [7:0] rdata_q, rdata_d;
    logic [1:0] cc_q, cc_d;
    logic [4:0] selcnt_q, selcnt_d;
    logic       hold_q, hold_d;
    logic       sel_q, sel_d;
    logic       adr_q, adr_d;
    logic       cmdt_q, cmdt_d;
    logic       svc_q, svc_d;
    logic       rvalid_q, rvalid_d;
    logic       sready_q, sready_d;
    logic       stop_q, stop_d;
    logic       endp_q, endp_d;   // service_out is answering ending status
    logic       perr_q, perr_d;   // a bad-parity byte was seen this op
    logic       op_q;

    logic       par_err;
    logic [7:0] sampled;
    logic       unused_request;

    // request-in is only meaningful for CU-initiated reconnection, which a
    // selector channel with one device does not use.
    assign unused_request = a_request_in;

    odd_parity u_out_par (.data(bus_q), .parity(a_bus_out_parity));

`ifdef BT_CHANNEL_PARITY_CHECK_EN
    logic in_par;
    odd_parity u_in_par (.data(a_bus_in), .parity(in_par));
    assign par_err = (in_par != a_bus_in_parity);
`else
    logic unused_in_parity;
    assign unused_in_parity = a_bus_in_parity;
    assign par_err          = 1'b0;
`endif

    // Any status byte taken during an op carrying a parity error reports
    // unit check, so the host sees it even if the CU's own status was clean.
    assign sampled = a_bus_in | ((par_err || perr_q) ? ST_UC : 8'h00);

    always_comb begin
        state_d  = state_q;
        bus_d    = bus_q;
        cmd_d    = cmd_q;
        status_d = status_q;
        rdata_d  = rdata_q;
        cc_d     = cc_q;
        selcnt_d = selcnt_q;
        hold_d   = hold_q;
        sel_d    = sel_q;
        adr_d    = adr_q;
        cmdt_d   = cmdt_q;
        svc_d    = svc_q;
        rvalid_d = rvalid_q;
        sready_d = sready_q;
        stop_d   = stop_q;
        endp_d   = endp_q;
        perr_d   = perr_q;

        if (state_q != IDLE) begin
            if (start) cc_d = CC_BUSY;
            if (stop)  stop_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    cmd_d    = command;
                    bus_d    = addr;
                    adr_d    = 1'b1;
                    cc_d     = CC_STARTED;
                    selcnt_d = '0;
                    perr_d   = 1'b0;
                    state_d  = SELECT;
                end
            end

            SELECT: begin
                selcnt_d = selcnt_q + 5'd1;
                if (!sel_q) begin
                    // address has been on the bus for a cycle; now select
                    hold_d = 1'b1;
                    sel_d  = 1'b1;
                end else if (a_select_in || selcnt_q == SEL_TIMEOUT) begin
                    // select propagated past the end of the chain: no CU
                    hold_d  = 1'b0;
                    sel_d   = 1'b0;
                    adr_d   = 1'b0;
                    bus_d   = '0;
                    stop_d  = 1'b0;
                    cc_d    = CC_NOT_OPER;
                    state_d = IDLE;
                end else if (a_operational_in && a_address_in) begin
                    hold_d  = 1'b0;
                    sel_d   = 1'b0;
                    adr_d   = 1'b0;
                    bus_d   = cmd_q;
                    cmdt_d  = 1'b1;
                    state_d = COMMAND;
                end
            end

            COMMAND: begin
                if (!a_address_in) begin
                    cmdt_d  = 1'b0;
                    bus_d   = '0;
                    state_d = INIT_STATUS;
                end
            end

            INIT_STATUS: begin
                if (!svc_q) begin
                    if (a_status_in) begin
                        status_d = sampled;
                        perr_d   = perr_q | par_err;
                        svc_d    = 1'b1;
                    end
                end else if (!a_status_in) begin
                    svc_d = 1'b0;
                    if (status_q == 8'h00) begin
                        state_d = DATA;
                    end else begin
                        cc_d    = CC_STORED;
                        state_d = END;
                    end
                end
            end

            DATA: begin
                if (svc_q) begin
                    if (endp_q) begin
                        if (!a_status_in) begin
                            svc_d   = 1'b0;
                            endp_d  = 1'b0;
                            state_d = END;
                        end
                    end else if (!a_service_in) begin
                        svc_d = 1'b0;
                        bus_d = '0;
                    end
                end else if (cmdt_q) begin
                    if (!a_service_in) cmdt_d = 1'b0;
                end else if (rvalid_q) begin
                    if (data_recv_tready) begin
                        rvalid_d = 1'b0;
                        svc_d    = 1'b1;
                    end else if (stop_q) begin
                        rvalid_d = 1'b0;
                        cmdt_d   = 1'b1;
                    end
                end else if (sready_q) begin
                    if (data_send_tvalid) begin
                        sready_d = 1'b0;
                        bus_d    = data_send_tdata;
                        svc_d    = 1'b1;
                    end else if (stop_q) begin
                        sready_d = 1'b0;
                        cmdt_d   = 1'b1;
                    end
                end else if (a_status_in) begin
                    status_d = sampled;
                    if (par_err || perr_q) cc_d = CC_STORED;
                    svc_d  = 1'b1;
                    endp_d = 1'b1;
                end else if (a_service_in) begin
                    if (cmd_is_read(cmd_q)) begin
                        if (par_err) begin
                            // refuse the corrupt byte; CU ends with status
                            perr_d = 1'b1;
                            cmdt_d = 1'b1;
                        end else begin
                            rdata_d  = a_bus_in;
                            rvalid_d = 1'b1;
                        end
                    end else if (cmd_is_write(cmd_q)) begin
                        sready_d = 1'b1;
                    end else begin
                        // control op has no data: answer a data request with stop
                        cmdt_d = 1'b1;
                    end
                end
            end

            END: begin
                hold_d   = 1'b0;
                sel_d    = 1'b0;
                adr_d    = 1'b0;
                cmdt_d   = 1'b0;
                svc_d    = 1'b0;
                endp_d   = 1'b0;
                rvalid_d = 1'b0;
                sready_d = 1'b0;
                bus_d    = '0;
                if (!a_operational_in) begin
                    stop_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        if (!enable) begin
            state_d  = IDLE;
            hold_d   = 1'b0;
            sel_d    = 1'b0;
            adr_d    = 1'b0;
            cmdt_d   = 1'b0;
            svc_d    = 1'b0;
            endp_d   = 1'b0;
            rvalid_d = 1'b0;
            sready_d = 1'b0;
            stop_d   = 1'b0;
            bus_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            bus_q    <= '0;
            cmd_q    <= '0;
            status_q <= '0;
            rdata_q  <= '0;
            cc_q     <= CC_STARTED;
            selcnt_q <= '0;
            hold_q   <= 1'b0;
            sel_q    <= 1'b0;
            adr_q    <= 1'b0;
            cmdt_q   <= 1'b0;
            svc_q    <= 1'b0;
            rvalid_q <= 1'b0;
            sready_q <= 1'b0;
            stop_q   <= 1'b0;
            endp_q   <= 1'b0;
            perr_q   <= 1'b0;
            op_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            bus_q    <= bus_d;
            cmd_q    <= cmd_d;
            status_q <= status_d;
            rdata_q  <= rdata_d;
            cc_q     <= cc_d;
            selcnt_q <= selcnt_d;
            hold_q   <= hold_d;
            sel_q    <= sel_d;
            adr_q    <= adr_d;
            cmdt_q   <= cmdt_d;
            svc_q    <= svc_d;
            rvalid_q <= rvalid_d;
            sready_q <= sready_d;
            stop_q   <= stop_d;
            endp_q   <= endp_d;
            perr_q   <= perr_d;
            op_q     <= enable;
        end
    end

    assign a_bus_out         = bus_q;
    assign a_operational_out = op_q;
    assign a_hold_out        = hold_q;
    assign a_select_out      = sel_q;
    assign a_address_out     = adr_q;
    assign a_command_out     = cmdt_q;
    assign a_service_out     = svc_q;
    assign a_suppress_out    = 1'b0;
    assign condition_code    = cc_q;
    assign status            = status_q;
    assign data_send_tready  = sready_q;
    assign data_recv_tdata   = rdata_q;
    assign data_recv_tvalid  = rvalid_q;

endmodule

// File: tb/tb_bt_channel.sv
// tb_bt_channel: table-driven bench for bt_channel with a behavioural CU on
// the chain (address 8'h1a, busy and byte-limit knobs) and a host model that
// counts bytes down and pulses stop at zero. Read bytes are queued when the
// CU drives them and checked when the host takes them; write bytes are queued
// at the host handshake and checked when the CU captures them.
module tb_bt_channel;
    import bt_channel_pkg::*;

    logic       clk = 1'b0;
    logic       reset, enable;
    logic [7:0] a_bus_out, a_bus_in;
    logic       a_bus_out_parity, a_bus_in_parity;
    logic       a_operational_out, a_hold_out, a_select_out, a_address_out;
    logic       a_command_out, a_service_out, a_suppress_out;
    logic       a_operational_in, a_request_in, a_select_in, a_address_in;
    logic       a_status_in, a_service_in;
    logic [7:0] addr, command;
    logic       start, stop;
    logic [1:0] condition_code;
    logic [7:0] status;
    logic [7:0] data_send_tdata, data_recv_tdata;
    logic       data_send_tvalid, data_send_tready;
    logic       data_recv_tvalid, data_recv_tready;

    int checks = 0;
    int errors = 0;

    // CU knobs / observations
    logic [7:0] cu_addr = 8'h1a;
    bit         cu_busy;
    int         cu_limit;
    int         cu_bytes;
    bit         cu_idle = 1'b1;
    logic [7:0] cur_cmd;

    // host model
    int host_mode;   // 0 none, 1 read, 2 write
    int host_cnt;
    int hs_cnt;

    logic [7:0] rd_q[$];
    logic [7:0] wr_q[$];

    typedef struct {
        logic [7:0] addr;
        logic [7:0] cmd;
        bit         busy;
        int         count;
        int         limit;
        int         bound;
        logic [1:0] cc;
        logic [7:0] st;
        int         hs;
        int         resid;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    assign a_bus_in_parity = ~^a_bus_in;

    bt_channel dut (
        .clk(clk), .reset(reset), .enable(enable),
        .a_bus_out(a_bus_out), .a_bus_out_parity(a_bus_out_parity),
        .a_bus_in(a_bus_in), .a_bus_in_parity(a_bus_in_parity),
        .a_operational_out(a_operational_out), .a_hold_out(a_hold_out),
        .a_select_out(a_select_out), .a_address_out(a_address_out),
        .a_command_out(a_command_out), .a_service_out(a_service_out),
        .a_suppress_out(a_suppress_out),
        .a_operational_in(a_operational_in), .a_request_in(a_request_in),
        .a_select_in(a_select_in), .a_address_in(a_address_in),
        .a_status_in(a_status_in), .a_service_in(a_service_in),
        .addr(addr), .command(command), .start(start), .stop(stop),
        .condition_code(condition_code), .status(status),
        .data_send_tdata(data_send_tdata), .data_send_tvalid(data_send_tvalid),
        .data_send_tready(data_send_tready),
        .data_recv_tdata(data_recv_tdata), .data_recv_tvalid(data_recv_tvalid),
        .data_recv_tready(data_recv_tready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cu_status(input logic [7:0] st);
        a_bus_in    = st;
        a_status_in = 1'b1;
        do @(negedge clk); while (!a_service_out);
        a_status_in = 1'b0;
        a_bus_in    = 8'h00;
        while (a_service_out) @(negedge clk);
    endtask

    task automatic cu_session();
        logic [7:0] c, st, exp;
        bit stopped;
        cu_idle          = 1'b0;
        a_operational_in = 1'b1;
        a_address_in     = 1'b1;
        a_bus_in         = cu_addr;
        while (!a_command_out) @(negedge clk);
        c = a_bus_out;
        chk("cu_cmd", 32'(c), 32'(cur_cmd));
        chk("cmd_parity", 32'(a_bus_out_parity), 32'(~^cur_cmd));
        a_address_in = 1'b0;
        a_bus_in     = 8'h00;
        while (a_command_out) @(negedge clk);
        if (cu_busy)                               st = ST_BUSY;
        else if (c == CMD_READ || c == CMD_WRITE)  st = 8'h00;
        else if (c == CMD_NOP)                     st = ST_CE | ST_DE;
        else                                       st = ST_UC;
        cu_status(st);
        if (st == 8'h00) begin
            stopped = 1'b0;
            for (int n = 0; n < cu_limit && !stopped; n++) begin
                if (c == CMD_READ) begin
                    a_bus_in = 8'h40 + 8'(n);
                    rd_q.push_back(a_bus_in);
                end
                a_service_in = 1'b1;
                @(negedge clk);
                while (!a_service_out && !a_command_out) @(negedge clk);
                if (a_command_out) begin
                    if (c == CMD_READ) void'(rd_q.pop_back());
                    stopped      = 1'b1;
                    a_service_in = 1'b0;
                    a_bus_in     = 8'h00;
                    while (a_command_out) @(negedge clk);
                end else begin
                    if (c == CMD_WRITE) begin
                        exp = (wr_q.size() > 0) ? wr_q.pop_front() : 8'hxx;
                        chk("wr_data", 32'(a_bus_out), 32'(exp));
                    end
                    cu_bytes++;
                    a_service_in = 1'b0;
                    a_bus_in     = 8'h00;
                    while (a_service_out) @(negedge clk);
                end
            end
            cu_status(ST_CE | ST_DE);
        end
        a_operational_in = 1'b0;
        cu_idle          = 1'b1;
    endtask

    // control unit on the chain
    initial begin
        a_operational_in = 1'b0;
        a_select_in      = 1'b0;
        a_address_in     = 1'b0;
        a_status_in      = 1'b0;
        a_service_in     = 1'b0;
        a_bus_in         = 8'h00;
        forever begin
            @(negedge clk);
            if (a_select_out && a_hold_out) begin
                if (a_bus_out != cu_addr) begin
                    a_select_in = 1'b1;
                    while (a_select_out) @(negedge clk);
                    a_select_in = 1'b0;
                end else begin
                    cu_session();
                end
            end
        end
    end

    // host data side
    initial begin
        logic [7:0] exp;
        stop             = 1'b0;
        data_recv_tready = 1'b0;
        data_send_tvalid = 1'b0;
        data_send_tdata  = 8'h00;
        forever begin
            @(negedge clk);
            stop = 1'b0;
            if (host_mode == 1) begin
                data_recv_tready = (host_cnt > 0);
                if (data_recv_tvalid && data_recv_tready) begin
                    exp = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hxx;
                    chk("rd_data", 32'(data_recv_tdata), 32'(exp));
                    hs_cnt++;
                    host_cnt--;
                    if (host_cnt == 0) stop = 1'b1;
                end
            end else if (host_mode == 2) begin
                data_send_tvalid = (host_cnt > 0);
                data_send_tdata  = 8'h99;
                if (data_send_tvalid && data_send_tready) begin
                    wr_q.push_back(8'h99);
                    hs_cnt++;
                    host_cnt--;
                    if (host_cnt == 0) stop = 1'b1;
                end
            end else begin
                data_recv_tready = 1'b0;
                data_send_tvalid = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int cyc = 0; cyc < bound; cyc++) begin
            @(negedge clk);
            if (!a_hold_out && !a_select_out && !a_address_out && !a_command_out &&
                !a_service_out && !a_operational_in && !a_select_in &&
                !data_recv_tvalid && !data_send_tready && cu_idle) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_start(input logic [7:0] a, input logic [7:0] c);
        addr    = a;
        command = c;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    initial begin
        bit ok;
        vecs[0] = '{8'h10, CMD_READ,  1'b0,  0, 16,  20, CC_NOT_OPER, 8'h00, 0,  0};
        vecs[1] = '{8'h1a, CMD_READ,  1'b1,  6, 16,  50, CC_STORED,   8'h10, 0,  6};
        vecs[2] = '{8'h1a, CMD_READ,  1'b0,  6, 16, 150, CC_STARTED,  8'h0c, 6,  0};
        vecs[3] = '{8'h1a, CMD_READ,  1'b0, 16,  6, 150, CC_STARTED,  8'h0c, 6, 10};
        vecs[4] = '{8'h1a, CMD_WRITE, 1'b0,  6, 16, 150, CC_STARTED,  8'h0c, 6,  0};
        vecs[5] = '{8'h1a, CMD_WRITE, 1'b0, 16,  6, 150, CC_STARTED,  8'h0c, 6, 10};
        vecs[6] = '{8'h1a, CMD_NOP,   1'b0,  4, 16,  50, CC_STORED,   8'h0c, 0,  4};
        vecs[7] = '{8'h1a, 8'hff,     1'b0,  4, 16,  50, CC_STORED,   8'h02, 0,  4};

        reset        = 1'b0;
        enable       = 1'b0;
        start        = 1'b0;
        addr         = 8'h00;
        command      = 8'h00;
        a_request_in = 1'b0;
        host_mode    = 0;
        host_cnt     = 0;
        hs_cnt       = 0;
        cu_busy      = 1'b0;
        cu_limit     = 0;
        cu_bytes     = 0;
        cur_cmd      = 8'h00;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);

        // reset state (enable high but reset still asserted)
        chk("rst_tags", 32'({a_operational_out, a_hold_out, a_select_out, a_address_out,
                             a_command_out, a_service_out, a_suppress_out}), 32'd0);
        chk("rst_bus", 32'(a_bus_out), 32'd0);
        chk("rst_parity", 32'(a_bus_out_parity), 32'd1);
        chk("rst_cc", 32'(condition_code), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_axis", 32'({data_send_tready, data_recv_tvalid}), 32'd0);

        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("op_out", 32'(a_operational_out), 32'd1);

        for (int i = 0; i < 8; i++) begin
            cu_busy   = vecs[i].busy;
            cu_limit  = vecs[i].limit;
            cu_bytes  = 0;
            cur_cmd   = vecs[i].cmd;
            host_cnt  = vecs[i].count;
            hs_cnt    = 0;
            host_mode = (vecs[i].cmd == CMD_WRITE) ? 2 : 1;
            pulse_start(vecs[i].addr, vecs[i].cmd);
            wait_idle(vecs[i].bound, ok);
            chk($sformatf("v%0d_idle_in_time", i), 32'(ok), 32'd1);
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d_cc", i), 32'(condition_code), 32'(vecs[i].cc));
            chk($sformatf("v%0d_status", i), 32'(status), 32'(vecs[i].st));
            chk($sformatf("v%0d_handshakes", i), 32'(hs_cnt), 32'(vecs[i].hs));
            chk($sformatf("v%0d_residual", i), 32'(host_cnt), 32'(vecs[i].resid));
            chk($sformatf("v%0d_cu_bytes", i), 32'(cu_bytes), 32'(vecs[i].hs));
            chk($sformatf("v%0d_queues", i), 32'(rd_q.size() + wr_q.size()), 32'd0);
            host_mode = 0;
            rd_q.delete();
            wr_q.delete();
            @(negedge clk);
        end

        // start while an op is in flight: reported busy, op continues
        cu_busy   = 1'b0;
        cu_limit  = 6;
        cu_bytes  = 0;
        cur_cmd   = CMD_READ;
        host_cnt  = 16;
        hs_cnt    = 0;
        host_mode = 1;
        pulse_start(8'h1a, CMD_READ);
        repeat (4) @(negedge clk);
        pulse_start(8'h1a, CMD_WRITE);
        chk("busy_start_cc", 32'(condition_code), 32'(CC_BUSY));
        wait_idle(150, ok);
        chk("busy_start_idle", 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
        chk("busy_start_hs", 32'(hs_cnt), 32'd6);
        chk("busy_start_cc_kept", 32'(condition_code), 32'(CC_BUSY));
        host_mode = 0;
        rd_q.delete();
        @(negedge clk);

        // enable low: operational drops and start raises no tags
        enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("dis_op_out", 32'(a_operational_out), 32'd0);
        pulse_start(8'h1a, CMD_READ);
        chk("dis_no_address", 32'({a_address_out, a_hold_out, a_select_out}), 32'd0);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        chk("reen_op_out", 32'(a_operational_out), 32'd1);

        // asynchronous reset while a read byte waits on the host
        cu_limit  = 16;
        cur_cmd   = CMD_READ;
        host_mode = 0;
        pulse_start(8'h1a, CMD_READ);
        ok = 1'b0;
        for (int cyc = 0; cyc < 60 && !ok; cyc++) begin
            @(negedge clk);
            ok = data_recv_tvalid;
        end
        chk("mid_rd_pending", 32'(ok), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_tags", 32'({a_operational_out, a_hold_out, a_select_out, a_address_out,
                                   a_command_out, a_service_out}), 32'd0);
        chk("async_rst_tvalid", 32'(data_recv_tvalid), 32'd0);
        chk("async_rst_parity", 32'(a_bus_out_parity), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
